// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int RADDR_W_DEF = 5;
    // wait counter is wide enough for the largest allowed MAX_WAIT (255)
    localparam int WAIT_W      = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_e;

    // One bundle of every control pin the controller drives into the datapath
    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
    } ctrl_t;

    // Control patterns, bit order follows ctrl_t
    localparam ctrl_t CTRL_RESET  = 7'b0000011; // everything held, buffers cleared
    localparam ctrl_t CTRL_FREEZE = 7'b0000000; // whole pipe holds
    localparam ctrl_t CTRL_RUN    = 7'b1111100; // normal advance
    localparam ctrl_t CTRL_SQUASH = 7'b1111111; // advance, kill IF and ID instructions
    localparam ctrl_t CTRL_BUBBLE = 7'b0011101; // hold PC/IF-ID, bubble into EX

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = 32
);
    logic [RADDR_W-1:0] id_rs1;
    logic [RADDR_W-1:0] id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_is_load;
    logic               ex_br_taken;
    logic               mem_req;
    logic               mem_ready;
    logic               pc_en;
    logic               en_ifid;
    logic               en_idex;
    logic               en_exmem;
    logic               en_memwb;
    logic               flush_ifid;
    logic               flush_idex;
    logic               mem_err;
    logic [CNT_W-1:0]   stall_cnt;

    // datapath side
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_br_taken, mem_req, mem_ready,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid,
               flush_idex, mem_err, stall_cnt
    );

    // controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_br_taken, mem_req, mem_ready,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid,
               flush_idex, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Combinational load-use hazard detector: ID reads a register a load in EX
// is still producing. x0 never creates a dependency.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0] i_rs1,
    input  logic [RADDR_W-1:0] i_rs2,
    input  logic               i_use_rs1,
    input  logic               i_use_rs2,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic               i_ex_is_load,
    output logic               o_load_use
);
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1  = i_use_rs1 && (i_rs1 == i_ex_rd);
    assign w_hit_rs2  = i_use_rs2 && (i_rs2 == i_ex_rd);
    assign o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline buffer sequencer: load-use bubbles, branch squash,
// data-memory wait freeze with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_load_use;
    logic              w_mem_stall;
    ctrl_t             w_ctrl;

    load_use_detect #(.RADDR_W(RADDR_W)) u_lu (
        .i_rs1       (bus.id_rs1),
        .i_rs2       (bus.id_rs2),
        .i_use_rs1   (bus.id_use_rs1),
        .i_use_rs2   (bus.id_use_rs2),
        .i_ex_rd     (bus.ex_rd),
        .i_ex_is_load(bus.ex_is_load),
        .o_load_use  (w_load_use)
    );

    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    // Next state and control decode; priority mem_stall > branch > load-use.
    // Reset overrides the decode so buffers clear while rst is held.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_ctrl      = CTRL_RUN;
        if (r_state == ST_TIMEOUT) begin
            w_ctrl = CTRL_FREEZE;
        end else if (w_mem_stall) begin
            w_ctrl = CTRL_FREEZE;
            if (r_state != ST_MEM_WAIT) begin
                w_state_nxt = ST_MEM_WAIT;
                w_wait_nxt  = WAIT_W'(1);
            end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                w_state_nxt = ST_TIMEOUT;
            end else begin
                w_wait_nxt  = r_wait_cnt + 1'b1;
            end
        end else begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
            if (bus.ex_br_taken)  w_ctrl = CTRL_SQUASH;
            else if (w_load_use)  w_ctrl = CTRL_BUBBLE;
        end
        if (!rst) w_ctrl = CTRL_RESET;
    end

    // FSM state and memory-wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Sticky timeout flag and saturating count of PC-held cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_state_nxt == ST_TIMEOUT) r_mem_err <= 1'b1;
            if (!w_ctrl.pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_en      = w_ctrl.pc_en;
    assign bus.en_ifid    = w_ctrl.en_ifid;
    assign bus.en_idex    = w_ctrl.en_idex;
    assign bus.en_exmem   = w_ctrl.en_exmem;
    assign bus.en_memwb   = w_ctrl.en_memwb;
    assign bus.flush_ifid = w_ctrl.flush_ifid;
    assign bus.flush_idex = w_ctrl.flush_idex;
    assign bus.mem_err    = r_mem_err;
    assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int RW   = 5;
    localparam int MW   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.RADDR_W(RW), .CNT_W(CW)) bus ();
    pipeline_hazard_ctrl #(.RADDR_W(RW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: length of the current unbroken memory stall, timeout flag, stall count
    int m_run;
    bit m_to;
    int m_cnt;

    function automatic logic [6:0] dut_vec();
        return {bus.pc_en, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
                bus.flush_ifid, bus.flush_idex};
    endfunction

    // expected {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex}
    function automatic logic [6:0] exp_vec();
        bit lu;
        lu = bus.ex_is_load && bus.ex_rd != 0 &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        if (!rst)                              return 7'b0000011;
        if (m_to)                              return 7'b0000000;
        if (bus.mem_req && !bus.mem_ready)     return 7'b0000000;
        if (bus.ex_br_taken)                   return 7'b1111111;
        if (lu)                                return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic model_reset();
        m_run = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_rd = '0; bus.ex_is_load = 0; bus.ex_br_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    // one clock edge; model advances using the pre-edge expectation
    task automatic tick();
        logic [6:0] e;
        bit stall;
        e = exp_vec();
        stall = bus.mem_req && !bus.mem_ready;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            if (!m_to) begin
                if (stall) begin
                    m_run++;
                    if (m_run > MW) m_to = 1;
                end else m_run = 0;
            end
            if (!e[6] && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 0; model_reset(); idle_inputs();
        repeat (3) tick();
        n_tests++;
        if (dut_vec() !== 7'b0000011) begin n_fail++; $display("FAIL reset_ctrl got %b want %b", dut_vec(), 7'b0000011); end
        n_tests++;
        if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt); end
        n_tests++;
        if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.mem_err); end
        rst = 1; #1;
        n_tests++;
        if (dut_vec() !== 7'b1111100) begin n_fail++; $display("FAIL release_ctrl got %b want %b", dut_vec(), 7'b1111100); end
        tick();
    endtask

    task automatic test_load_use();
        int c0;
        c0 = m_cnt;
        bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_use_rs2 = 1; #1;
        n_tests++;
        if (dut_vec() !== 7'b0011101) begin n_fail++; $display("FAIL lu_ctrl got %b want %b", dut_vec(), 7'b0011101); end
        tick();
        n_tests++;
        if (bus.stall_cnt !== CW'(c0 + 1)) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", bus.stall_cnt, c0 + 1); end
        bus.ex_rd = 0; bus.id_rs2 = 0; #1;
        n_tests++;
        if (dut_vec() !== 7'b1111100) begin n_fail++; $display("FAIL lu_x0 got %b want %b", dut_vec(), 7'b1111100); end
        tick(); idle_inputs();
    endtask

    task automatic test_branch_lu();
        int c0;
        c0 = m_cnt;
        bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
        bus.ex_br_taken = 1; #1;
        n_tests++;
        if (dut_vec() !== 7'b1111111) begin n_fail++; $display("FAIL br_ctrl got %b want %b", dut_vec(), 7'b1111111); end
        tick();
        n_tests++;
        if (bus.stall_cnt !== CW'(c0)) begin n_fail++; $display("FAIL br_cnt got %0d want %0d", bus.stall_cnt, c0); end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        int c0;
        c0 = m_cnt;
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (dut_vec() !== 7'b0000000) begin n_fail++; $display("FAIL wait_frz%0d got %b want 0000000", i, dut_vec()); end
            tick();
        end
        bus.mem_ready = 1; #1;
        n_tests++;
        if (dut_vec() !== 7'b1111100) begin n_fail++; $display("FAIL wait_done got %b want %b", dut_vec(), 7'b1111100); end
        tick();
        n_tests++;
        if (bus.stall_cnt !== CW'(c0 + 3)) begin n_fail++; $display("FAIL wait_cnt got %0d want %0d", bus.stall_cnt, c0 + 3); end
        // a fresh wait of MAX_WAIT cycles must not time out once back in RUN
        bus.mem_ready = 0;
        repeat (MW) tick();
        bus.mem_ready = 1; tick();
        n_tests++;
        if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL wait_rearm got %b want 0", bus.mem_err); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (MW) tick();
        n_tests++;
        if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", bus.mem_err); end
        tick();
        n_tests++;
        if (bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", bus.mem_err); end
        bus.mem_ready = 1; bus.ex_br_taken = 1; #1;
        n_tests++;
        if (dut_vec() !== 7'b0000000) begin n_fail++; $display("FAIL to_frozen got %b want 0000000", dut_vec()); end
        repeat (3) tick();
        n_tests++;
        if (bus.mem_err !== 1'b1 || dut_vec() !== 7'b0000000) begin
            n_fail++; $display("FAIL to_sticky err %b ctrl %b want 1/0000000", bus.mem_err, dut_vec());
        end
        rst = 0; model_reset(); #1;
        n_tests++;
        if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", bus.mem_err); end
        tick(); rst = 1; idle_inputs(); tick();
    endtask

    task automatic test_async_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (2) tick();
        #2; rst = 0; model_reset(); #1;
        n_tests++;
        if (dut_vec() !== 7'b0000011) begin n_fail++; $display("FAIL async_ctrl got %b want %b", dut_vec(), 7'b0000011); end
        n_tests++;
        if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL async_cnt got %0d want 0", bus.stall_cnt); end
        tick(); rst = 1; idle_inputs(); #1;
        n_tests++;
        if (dut_vec() !== 7'b1111100) begin n_fail++; $display("FAIL async_resume got %b want %b", dut_vec(), 7'b1111100); end
        tick();
    endtask

    task automatic test_saturate();
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (CMAX + 10) tick();
        n_tests++;
        if (bus.stall_cnt !== CW'(CMAX) || m_cnt != CMAX) begin
            n_fail++; $display("FAIL sat_cnt got %0d want %0d", bus.stall_cnt, CMAX);
        end
        rst = 0; model_reset(); tick(); rst = 1; idle_inputs(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.id_rs1      = RW'($urandom_range(0, 3));
            bus.id_rs2      = RW'($urandom_range(0, 3));
            bus.ex_rd       = RW'($urandom_range(0, 3));
            bus.id_use_rs1  = 1'($urandom_range(0, 1));
            bus.id_use_rs2  = 1'($urandom_range(0, 1));
            bus.ex_is_load  = 1'($urandom_range(0, 1));
            bus.ex_br_taken = ($urandom_range(0, 3) == 0);
            bus.mem_req     = ($urandom_range(0, 2) == 0);
            bus.mem_ready   = ($urandom_range(0, 2) != 0);
            if (m_to && $urandom_range(0, 7) == 0) begin rst = 0; model_reset(); end
            else rst = 1;
            #1;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rnd_ctrl@%0d got %b want %b", i, dut_vec(), exp_vec()); end
            n_tests++;
            if (bus.stall_cnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt@%0d got %0d want %0d", i, bus.stall_cnt, m_cnt); end
            n_tests++;
            if (bus.mem_err !== m_to) begin n_fail++; $display("FAIL rnd_err@%0d got %b want %b", i, bus.mem_err, m_to); end
            tick();
        end
        rst = 1; idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
